alu_cmd_stage: RTL and testbench

Registered command/result stage wrapped around the combinational ALU. It accepts ALU commands (A, B, F, Cin) over a valid/ready handshake and holds them in an operand register that drives the ALU. The next cycle it captures Out and Status into a 2-entry result FIFO presented downstream over valid/ready. It also keeps a sticky OR of Status bits and a per-command sequence tag, which gives the ALU clean registered boundaries on both sides.

---
 rtl/alu_cmd_stage.sv | 136 +++++++++++++
 tb/tb_alu_cmd_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_stage.sv
// Registered command/result stage around a combinational ALU: operand register on the
// input side, 2-entry result FIFO on the output side, sticky status OR and sequence tags.
module alu_cmd_stage #(
  parameter int Width = 16,
  parameter int SeqW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_a,
  input  logic [Width-1:0] in_b,
  input  logic [4:0]       in_f,
  input  logic             in_cin,
  output logic [Width-1:0] alu_a,
  output logic [Width-1:0] alu_b,
  output logic [4:0]       alu_f,
  output logic             alu_cin,
  input  logic [Width-1:0] alu_out,
  input  logic [5:0]       alu_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic [5:0]       out_status,
  output logic [SeqW-1:0]  out_seq,
  output logic [5:0]       sticky_status,
  input  logic             sticky_clr
);

  logic             op_vld;
  logic [Width-1:0] op_a;
  logic [Width-1:0] op_b;
  logic [4:0]       op_f;
  logic             op_cin;
  logic [SeqW-1:0]  op_seq;
  logic [SeqW-1:0]  acc_seq;

  logic [1:0]       fifo_cnt;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [Width-1:0] fifo_data   [2];
  logic [5:0]       fifo_status [2];
  logic [SeqW-1:0]  fifo_seq    [2];

  logic space;
  logic drain;
  logic accept;
  logic pop;

  // Space looks only at the registered count, so out_ready never reaches in_ready.
  assign space    = (fifo_cnt < 2'd2);
  assign drain    = op_vld && space;
  assign in_ready = !rst && (!op_vld || space);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_f   = op_f;
  assign alu_cin = op_cin;

  assign out_valid  = (fifo_cnt != 2'd0);
  assign out_data   = fifo_data[rd_ptr];
  assign out_status = fifo_status[rd_ptr];
  assign out_seq    = fifo_seq[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_vld  <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_f    <= '0;
      op_cin  <= 1'b0;
      op_seq  <= '0;
      acc_seq <= '0;
    end else begin
      if (accept) begin
        op_vld  <= 1'b1;
        op_a    <= in_a;
        op_b    <= in_b;
        op_f    <= in_f;
        op_cin  <= in_cin;
        op_seq  <= acc_seq;
        acc_seq <= acc_seq + 1'b1;
      end else if (drain) begin
        op_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt       <= 2'd0;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      fifo_data[0]   <= '0;
      fifo_data[1]   <= '0;
      fifo_status[0] <= '0;
      fifo_status[1] <= '0;
      fifo_seq[0]    <= '0;
      fifo_seq[1]    <= '0;
    end else begin
      if (drain) begin
        fifo_data[wr_ptr]   <= alu_out;
        fifo_status[wr_ptr] <= alu_status;
        fifo_seq[wr_ptr]    <= op_seq;
        wr_ptr              <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({drain, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // A clear coinciding with a drain keeps only the freshly captured status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_status <= '0;
    end else begin
      sticky_status <= (sticky_clr ? 6'd0 : sticky_status) | (drain ? alu_status : 6'd0);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(drain && fifo_cnt == 2'd2));
      assert (!(pop && fifo_cnt == 2'd0));
    end
  end

endmodule

// File: tb/tb_alu_cmd_stage.sv
// Bench for alu_cmd_stage: XOR ALU stub, queue-based reference model checked every
// negedge, plus directed scenarios with hand-computed literal expectations.
module tb_alu_cmd_stage;
  localparam int Width = 16;
  localparam int SeqW  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [Width-1:0] in_a = '0;
  logic [Width-1:0] in_b = '0;
  logic [4:0]       in_f = '0;
  logic             in_cin = 1'b0;
  logic [Width-1:0] alu_a;
  logic [Width-1:0] alu_b;
  logic [4:0]       alu_f;
  logic             alu_cin;
  logic [Width-1:0] alu_out;
  logic [5:0]       alu_status;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [Width-1:0] out_data;
  logic [5:0]       out_status;
  logic [SeqW-1:0]  out_seq;
  logic [5:0]       sticky_status;
  logic             sticky_clr = 1'b0;

  alu_cmd_stage #(.Width(Width), .SeqW(SeqW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_f(in_f), .in_cin(in_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_status(alu_status),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_status(out_status), .out_seq(out_seq),
    .sticky_status(sticky_status), .sticky_clr(sticky_clr)
  );

  assign alu_out    = alu_a ^ alu_b;
  assign alu_status = {alu_f, alu_cin};

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: q holds every command inside the stage in order; the first ndr
  // of them have reached the result FIFO, any remaining one sits in the operand register.
  typedef struct {
    logic [Width-1:0] d;
    logic [5:0]       st;
    logic [SeqW-1:0]  seq;
  } exp_t;

  exp_t             q[$];
  int               ndr = 0;
  logic [5:0]       m_sticky = '0;
  logic [SeqW-1:0]  m_seq = '0;
  logic [Width-1:0] m_a = '0;
  logic [Width-1:0] m_b = '0;
  logic [4:0]       m_f = '0;
  logic             m_cin = 1'b0;
  int               pop_count = 0;
  logic [SeqW-1:0]  pop_log[$];
  bit               m_full, m_rdy, m_acc, m_drn, m_pop;
  exp_t             m_new;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pop_log.delete();
      ndr = 0; m_sticky = '0; m_seq = '0;
      m_a = '0; m_b = '0; m_f = '0; m_cin = 1'b0;
    end
    m_full = (q.size() > ndr);
    m_rdy  = !rst && (!m_full || ndr < 2);
    check("in_ready", 32'(in_ready), 32'(m_rdy));
    check("out_valid", 32'(out_valid), 32'(ndr > 0));
    if (ndr > 0) begin
      check("out_data", 32'(out_data), 32'(q[0].d));
      check("out_status", 32'(out_status), 32'(q[0].st));
      check("out_seq", 32'(out_seq), 32'(q[0].seq));
    end
    check("sticky", 32'(sticky_status), 32'(m_sticky));
    check("alu_a", 32'(alu_a), 32'(m_a));
    check("alu_b", 32'(alu_b), 32'(m_b));
    check("alu_fc", 32'({alu_f, alu_cin}), 32'({m_f, m_cin}));
    if (!rst) begin
      m_acc = in_valid && m_rdy;
      m_drn = m_full && ndr < 2;
      m_pop = (ndr > 0) && out_ready;
      m_sticky = (sticky_clr ? 6'd0 : m_sticky) | (m_drn ? q[ndr].st : 6'd0);
      if (m_pop) begin
        pop_log.push_back(out_seq);
        pop_count++;
        void'(q.pop_front());
        ndr--;
      end
      if (m_drn) ndr++;
      if (m_acc) begin
        m_new.d   = in_a ^ in_b;
        m_new.st  = {in_f, in_cin};
        m_new.seq = m_seq;
        q.push_back(m_new);
        m_seq = m_seq + 1'b1;
        m_a = in_a; m_b = in_b; m_f = in_f; m_cin = in_cin;
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [4:0] f,
                      input logic c, input int max_cyc, output bit ok);
    bit r;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_f = f; in_cin = c;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
  endtask

  task automatic send_ok(input logic [15:0] a, input logic [15:0] b, input logic [4:0] f,
                         input logic c);
    bit ok;
    send(a, b, f, c, 50, ok);
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int p0;
  bit ok4;

  initial begin
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sticky", 32'(sticky_status), 32'd0);
    @(posedge clk); #1;
    do_reset();

    // Single command
    out_ready = 1'b1;
    send_ok(16'h00FF, 16'h0F0F, 5'd3, 1'b1);
    in_valid = 1'b0;
    check("single_lat_n", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h0FF0);
    check("single_status", 32'(out_status), 32'h07);
    check("single_seq", 32'(out_seq), 32'd0);
    check("single_sticky", 32'(sticky_status), 32'h07);
    idle(3);

    // Streaming
    do_reset();
    out_ready = 1'b1;
    stalls = 0;
    p0 = pop_count;
    send_ok(16'h1234, 16'h00FF, 5'd1, 1'b0);
    send_ok(16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom));
    check("stream_first_data", 32'(out_data), 32'h12CB);
    check("stream_first_seq", 32'(out_seq), 32'd0);
    for (int i = 2; i < 20; i++)
      send_ok(16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom));
    idle(4);
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_pops", 32'(pop_count - p0), 32'd20);
    check("stream_last_seq", 32'(pop_log[19]), 32'd19);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    send_ok(16'h0001, 16'h0000, 5'd1, 1'b0);
    send_ok(16'h0002, 16'h0000, 5'd2, 1'b0);
    send_ok(16'h0003, 16'h0000, 5'd3, 1'b0);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    send(16'h0004, 16'h0000, 5'd4, 1'b0, 5, ok4);
    check("bp_fourth_blocked", 32'(ok4), 32'd0);
    check("bp_head_seq", 32'(out_seq), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after_pop", 32'(in_ready), 32'd1);
    check("bp_head_after_pop", 32'(out_seq), 32'd1);
    send_ok(16'h0004, 16'h0000, 5'd4, 1'b0);
    idle(5);
    check("bp_pops", 32'(pop_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("bp_order", 32'(pop_log[i]), 32'(i));

    // Sticky clear
    do_reset();
    out_ready = 1'b1;
    send_ok(16'h0000, 16'h0000, 5'b00000, 1'b1);
    send_ok(16'h0000, 16'h0000, 5'b10000, 1'b0);
    idle(3);
    check("sticky_accum", 32'(sticky_status), 32'h21);
    send_ok(16'h0000, 16'h0000, 5'b00011, 1'b0);
    in_valid = 1'b0;
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    check("sticky_clr_write", 32'(sticky_status), 32'h06);
    idle(2);

    // Sequence wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 258; i++)
      send_ok(16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom));
    idle(4);
    check("wrap_count", 32'(pop_log.size()), 32'd258);
    check("wrap_254", 32'(pop_log[254]), 32'd254);
    check("wrap_255", 32'(pop_log[255]), 32'd255);
    check("wrap_256", 32'(pop_log[256]), 32'd0);
    check("wrap_257", 32'(pop_log[257]), 32'd1);

    // Reset mid-operation
    do_reset();
    out_ready = 1'b0;
    send_ok(16'hAAAA, 16'h5555, 5'h1F, 1'b1);
    send_ok(16'h1111, 16'h2222, 5'h1F, 1'b1);
    send_ok(16'h3333, 16'h4444, 5'h1F, 1'b1);
    in_valid = 1'b0;
    check("mid_full", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd0);
    check("mid_sticky", 32'(sticky_status), 32'd0);
    check("mid_alu", 32'({alu_a, alu_f, alu_cin}), 32'd0);
    check("mid_alu_b", 32'(alu_b), 32'd0);
    check("mid_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_ok(16'h00AA, 16'h0055, 5'd2, 1'b0);
    idle(4);
    check("mid_after_count", 32'(pop_log.size()), 32'd1);
    check("mid_after_seq", 32'(pop_log[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
